stack_nch: RTL
==============

Name: stack_nch

Overview:
- Parametrised successor to the single stack: NCH independent LIFO stacks, each DEPTH x DWID, sharing one memory array.
- Push and pop carry their own channel selects, so a push to one channel and a pop from another can complete in the same cycle.
- Adds registered pop data with valid/channel tags, per-channel full and empty flags, and sticky overflow/underflow errors.
- Used wherever several contexts need private return or operand stacks, such as per-thread call stacks.

Parameters:
- DEPTH, 256, entries per channel; power of 2, at least 2.
- DWID, 16, data width in bits.
- NCH, 4, number of channels; at least 1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- push  in  1  push request.
- push_ch  in  CHW  channel for push; CHW = max(1, clog2(NCH)).
- din  in  DWID  push data.
- pop  in  1  pop request.
- pop_ch  in  CHW  channel for pop.
- dout  out  DWID  popped data, registered.
- dout_vld  out  1  one-cycle strobe; dout/dout_ch are valid.
- dout_ch  out  CHW  channel of dout.
- empty  out  NCH  per-channel empty flag.
- full  out  NCH  per-channel full flag.
- ovf  out  NCH  sticky: push to a full channel.
- unf  out  NCH  sticky: pop from an empty channel.
- clr_err  in  1  clears all ovf/unf bits.

Behaviour:
- Storage:
  - Memory holds NCH*DEPTH words, addressed {ch, ptr}.
  - Each channel has a stack pointer sp[ch] in the range 0..DEPTH, DEPTH+1 values wide.
  - empty = (sp==0); full = (sp==DEPTH). Both are combinational from sp.
- Reset (clk edge with rst=1):
  - All sp=0, so empty=all 1s and full=0.
  - dout=0, dout_vld=0, dout_ch=0, ovf=0, unf=0.
  - Memory contents are not cleared.
  - rst takes priority over push, pop and clr_err; a push/pop in flight during reset is discarded.
- Push (ch=push_ch, not full): mem[{ch,sp}] <= din; sp++.
- Pop (ch=pop_ch, not empty):
  - dout <= mem[{ch,sp-1}], dout_ch <= ch, dout_vld <= 1 on the next cycle; sp--.
  - Latency is 1 clock from pop to dout_vld.
  - dout holds its last value when dout_vld=0.
- Push and pop on different channels: both execute independently in the same cycle.
- Push and pop on the same channel, channel not empty:
  - Replace: dout gets the old top; din is written to the same address mem[{ch,sp-1}]; sp unchanged.
  - Read-before-write is required, and this is permitted even when the channel is full.
- Push and pop on the same channel, channel empty: the pop underflows (unf set, no dout_vld); the push executes and sp becomes 1.
- Push when full (no same-channel pop): data dropped, sp unchanged, ovf[ch] <= 1.
- Pop when empty: ignored, dout_vld=0, unf[ch] <= 1.
- Error flags: ovf/unf stay set until clr_err or rst. If clr_err and a new error occur in the same cycle, the new error wins and the bit stays set.
- Channel select out of range (ch >= NCH): request ignored, no flag change.
- DEPTH wrap: sp never exceeds DEPTH and never goes below 0; there is no wrap-around.

Optional Feature:
- Macro: STACK_NCH_LEVEL_EN.
- Defined:
  - Adds output port level (NCH*(clog2(DEPTH)+1) bits), the flattened sp of every channel, channel 0 in the LSBs.
  - Adds output almost_full (NCH bits), set when sp >= DEPTH-2.
- Undefined: neither port exists and no logic is generated for them.

Decomposition:
- Package stack_pkg holds:
  - function clog2;
  - constants for the default DEPTH/DWID/NCH;
  - derived widths PTRW=clog2(DEPTH), CNTW=PTRW+1, CHW.
- Sub-module stack_ptr, generated once per channel:
  - inputs: inc, dec, clr_err, ovf_in, unf_in;
  - outputs: sp, empty, full, ovf, unf.
- The top level holds the memory, address muxes, dout register and same-channel replace logic.

Test Plan (DEPTH=256, DWID=16, NCH=4):
- Reset, then push 0x000A..0x0109 to ch0 (256 pushes).
  - Expect full[0]=1, other flags 0.
  - Then 256 pops from ch0 give dout 0x0109 down to 0x000A, each one cycle after its pop with dout_ch=0; finally empty[0]=1.
- Push 0x0011, 0x0022 to ch1 and 0x0033 to ch2. Then pop ch2 while pushing 0x0044 to ch1.
  - Expect dout=0x0033, dout_ch=2; sp[1]=3.
  - Subsequent ch1 pops give 0x0044, 0x0022, 0x0011.
- Push 20 words 0x000B..0x001E to ch3, then 10 cycles of push+pop on ch3 with din=0x0100+i.
  - Each pop returns the previous top (0x001E, 0x0100, ... 0x0108); level stays 20.
  - The final 12 pops start at 0x0109 and then continue 0x001D, 0x001C, ... down to 0x0013.
- Pop empty ch0: dout_vld stays 0, unf=0b0001.
  - Fill ch0 and push 0x5555: ovf=0b0001, next pop returns the last valid word.
  - clr_err clears both flags.
- Assert rst mid-burst while pushing ch1: after reset all empty=1, dout_vld=0, ovf=unf=0; a pop of ch1 flags unf[1].
- With STACK_NCH_LEVEL_EN defined, push 254 words to ch2.
  - Expect almost_full[2]=1 at sp=254.
  - level field for ch2 reads 254, then 255 and 256 after further pushes.

Source files
------------

// File: rtl/stack_pkg.sv
// +----------------------------------------------------------------------------+
// | Module : stack_pkg                                                          |
// | Brief  : Shared widths, defaults and width helpers for the multi-channel    |
// |          stack.                                                             |
// | Rev    : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package stack_pkg;

    // Ceiling log2; loop bound is constant so this elaborates cleanly.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // A single channel still needs a 1-bit select port.
    function automatic int chan_w(input int nch);
        return (clog2(nch) > 1) ? clog2(nch) : 1;
    endfunction

    localparam int c_DEF_DEPTH = 256;
    localparam int c_DEF_DWID  = 16;
    localparam int c_DEF_NCH   = 4;

    localparam int PTRW = clog2(c_DEF_DEPTH);
    localparam int CNTW = PTRW + 1;
    localparam int CHW  = chan_w(c_DEF_NCH);

endpackage

`default_nettype wire

// File: rtl/stack_ptr.sv
// +----------------------------------------------------------------------------+
// | Module : stack_ptr                                                          |
// | Brief  : Per-channel stack pointer with empty/full flags and sticky         |
// |          overflow/underflow bits.                                           |
// | Rev    : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module stack_ptr
    import stack_pkg::*;
#(
    parameter int DEPTH = c_DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inc,
    input  logic                   dec,
    input  logic                   clr_err,
    input  logic                   ovf_in,
    input  logic                   unf_in,
    output logic [clog2(DEPTH):0]  sp,
    output logic                   empty,
    output logic                   full,
    output logic                   ovf,
    output logic                   unf
);

    localparam int                c_CNTW  = clog2(DEPTH) + 1;
    localparam logic [c_CNTW-1:0] c_DEPTH = c_CNTW'(DEPTH);
    localparam logic [c_CNTW-1:0] c_ONE   = c_CNTW'(1);

    logic [c_CNTW-1:0] r_sp;
    logic              r_ovf;
    logic              r_unf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp  <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            // Saturating: the pointer never wraps past either end.
            if (inc && !dec && (r_sp != c_DEPTH)) begin
                r_sp <= r_sp + c_ONE;
            end else if (dec && !inc && (r_sp != '0)) begin
                r_sp <= r_sp - c_ONE;
            end
            // A fresh error in the clearing cycle keeps its bit set.
            r_ovf <= ovf_in | (r_ovf & ~clr_err);
            r_unf <= unf_in | (r_unf & ~clr_err);
        end
    end

    assign sp    = r_sp;
    assign empty = (r_sp == '0);
    assign full  = (r_sp == c_DEPTH);
    assign ovf   = r_ovf;
    assign unf   = r_unf;

endmodule

`default_nettype wire

// File: rtl/stack_nch.sv
// +----------------------------------------------------------------------------+
// | Module : stack_nch                                                          |
// | Brief  : NCH independent LIFO stacks sharing one memory; optional level /   |
// |          almost_full outputs enabled by macro STACK_NCH_LEVEL_EN.           |
// | Rev    : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module stack_nch
    import stack_pkg::*;
#(
    parameter int DEPTH = c_DEF_DEPTH,
    parameter int DWID  = c_DEF_DWID,
    parameter int NCH   = c_DEF_NCH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              push,
    input  logic [chan_w(NCH)-1:0]            push_ch,
    input  logic [DWID-1:0]                   din,
    input  logic                              pop,
    input  logic [chan_w(NCH)-1:0]            pop_ch,
    output logic [DWID-1:0]                   dout,
    output logic                              dout_vld,
    output logic [chan_w(NCH)-1:0]            dout_ch,
    output logic [NCH-1:0]                    empty,
    output logic [NCH-1:0]                    full,
    output logic [NCH-1:0]                    ovf,
    output logic [NCH-1:0]                    unf,
`ifdef STACK_NCH_LEVEL_EN
    output logic [NCH*(clog2(DEPTH)+1)-1:0]   level,
    output logic [NCH-1:0]                    almost_full,
`endif
    input  logic                              clr_err
);

    localparam int                 c_PTRW = clog2(DEPTH);
    localparam int                 c_CNTW = c_PTRW + 1;
    localparam int                 c_CHW  = chan_w(NCH);
    localparam int                 c_AW   = c_CHW + c_PTRW;
    localparam int                 c_MEMN = NCH * DEPTH;
    localparam logic [c_CNTW-1:0]  c_ONE  = c_CNTW'(1);
    localparam logic [c_CHW:0]     c_NCH  = (c_CHW + 1)'(NCH);

    logic [DWID-1:0]   r_mem [c_MEMN];
    logic [DWID-1:0]   r_dout;
    logic              r_dout_vld;
    logic [c_CHW-1:0]  r_dout_ch;

    logic [c_CNTW-1:0] w_sp [NCH];
    logic [NCH-1:0]    w_inc;
    logic [NCH-1:0]    w_dec;
    logic [NCH-1:0]    w_ovf_set;
    logic [NCH-1:0]    w_unf_set;

    logic              w_push_ok;
    logic              w_pop_ok;
    logic              w_same;
    logic [c_CNTW-1:0] w_push_sp;
    logic              w_push_full;
    logic [c_CNTW-1:0] w_pop_sp;
    logic              w_pop_empty;
    logic              w_rd;
    logic              w_replace;
    logic              w_wr;
    logic [c_CNTW-1:0] w_wsp;
    logic [c_CNTW-1:0] w_rsp;
    logic [c_AW-1:0]   w_waddr;
    logic [c_AW-1:0]   w_raddr;

    // Out-of-range channel selects are dropped before any state is touched.
    assign w_push_ok = push && ({1'b0, push_ch} < c_NCH);
    assign w_pop_ok  = pop  && ({1'b0, pop_ch}  < c_NCH);
    assign w_same    = w_push_ok && w_pop_ok && (push_ch == pop_ch);

    always_comb begin
        w_push_sp   = '0;
        w_push_full = 1'b0;
        w_pop_sp    = '0;
        w_pop_empty = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            if (push_ch == c_CHW'(c)) begin
                w_push_sp   = w_sp[c];
                w_push_full = full[c];
            end
            if (pop_ch == c_CHW'(c)) begin
                w_pop_sp    = w_sp[c];
                w_pop_empty = empty[c];
            end
        end
    end

    // Same-channel push+pop on a non-empty stack overwrites the top in place.
    assign w_rd      = w_pop_ok && !w_pop_empty;
    assign w_replace = w_same && w_rd;
    assign w_wr      = w_push_ok && (!w_push_full || w_replace);
    assign w_wsp     = w_replace ? (w_push_sp - c_ONE) : w_push_sp;
    assign w_rsp     = w_pop_sp - c_ONE;
    assign w_waddr   = {push_ch, w_wsp[c_PTRW-1:0]};
    assign w_raddr   = {pop_ch,  w_rsp[c_PTRW-1:0]};

    generate
        for (genvar c = 0; c < NCH; c++) begin : g_ch
            logic w_push_hit;
            logic w_pop_hit;

            assign w_push_hit   = w_push_ok && (push_ch == c_CHW'(c));
            assign w_pop_hit    = w_pop_ok  && (pop_ch  == c_CHW'(c));
            assign w_inc[c]     = w_push_hit && !full[c]  && !w_replace;
            assign w_dec[c]     = w_pop_hit  && !empty[c] && !w_replace;
            assign w_ovf_set[c] = w_push_hit && full[c]   && !w_replace;
            assign w_unf_set[c] = w_pop_hit  && empty[c];

            stack_ptr #(
                .DEPTH   (DEPTH)
            ) u_ptr (
                .clk     (clk),
                .rst     (rst),
                .inc     (w_inc[c]),
                .dec     (w_dec[c]),
                .clr_err (clr_err),
                .ovf_in  (w_ovf_set[c]),
                .unf_in  (w_unf_set[c]),
                .sp      (w_sp[c]),
                .empty   (empty[c]),
                .full    (full[c]),
                .ovf     (ovf[c]),
                .unf     (unf[c])
            );

`ifdef STACK_NCH_LEVEL_EN
            assign level[c*c_CNTW +: c_CNTW] = w_sp[c];
            assign almost_full[c]            = (w_sp[c] >= c_CNTW'(DEPTH - 2));
`endif
        end
    endgenerate

    // Storage is never reset; a write in a reset cycle is discarded.
    always_ff @(posedge clk) begin
        if (w_wr && !rst) begin
            r_mem[w_waddr] <= din;
        end
    end

    // The read samples the pre-write word, giving replace its old-top value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout     <= '0;
            r_dout_vld <= 1'b0;
            r_dout_ch  <= '0;
        end else begin
            r_dout_vld <= w_rd;
            if (w_rd) begin
                r_dout    <= r_mem[w_raddr];
                r_dout_ch <= pop_ch;
            end
        end
    end

    assign dout     = r_dout;
    assign dout_vld = r_dout_vld;
    assign dout_ch  = r_dout_ch;

endmodule

`default_nettype wire
